// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Decode front end ahead of the immediate sign extender. Classifies each
//   LEGv8 opcode into the extender Ctrl value and passes instr[25:0] through.
//   Outputs are registered. A main register (M) drives out_* and a skid
//   register (S) absorbs one extra entry, so in_ready is always a flop output.
// Ports
//   CLK, resetl            clock (rising edge), async active-low reset
//   flush                  synchronous discard of M and S, drops same-cycle input
//   in_valid/in_ready      upstream handshake
//   in_instr, in_pc        instruction word and its PC
//   out_valid/out_ready    downstream handshake
//   out_imm26              instr[25:0] of the output entry
//   out_ext_ctrl           sign-extender Ctrl of the output entry
//   out_imm_used           entry carries an immediate
//   out_pc                 PC of the output entry
module imm_decode_stage #(
  parameter int unsigned PC_W       = 64,
  parameter logic [2:0]  NOIMM_CTRL = 3'b000
) (
  input  logic            CLK,
  input  logic            resetl,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [25:0]     out_imm26,
  output logic [2:0]      out_ext_ctrl,
  output logic            out_imm_used,
  output logic [PC_W-1:0] out_pc
);

  typedef struct packed {
    logic [25:0]     imm26;
    logic [2:0]      ctrl;
    logic            used;
    logic [PC_W-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  localparam entry_t ResetEntry = '{imm26: '0, ctrl: NOIMM_CTRL, used: 1'b0, pc: '0};

  state_e state_q, state_d;
  entry_t m_q, m_d, s_q, s_d;
  entry_t in_entry;
  logic   in_ready_q;
  logic   dec_used;
  logic   [2:0] dec_ctrl;
  logic   acc, drn;

  // Opcode classification, longest opcode first.
  always_comb begin
    dec_ctrl = NOIMM_CTRL;
    dec_used = 1'b0;
    if (in_instr[31:21] == 11'b11111000010 || in_instr[31:21] == 11'b11111000000) begin
      dec_ctrl = 3'b010;
      dec_used = 1'b1;
    end else if (in_instr[31:22] == 10'b1001000100 || in_instr[31:22] == 10'b1101000100 ||
                 in_instr[31:22] == 10'b1001001000 || in_instr[31:22] == 10'b1011001000) begin
      dec_ctrl = 3'b011;
      dec_used = 1'b1;
    end else if (in_instr[31:23] == 9'b110100101) begin
      dec_ctrl = {1'b1, in_instr[22:21]};
      dec_used = 1'b1;
    end else if (in_instr[31:25] == 7'b1011010) begin
      // CBZ (10110100) and CBNZ (10110101)
      dec_ctrl = 3'b001;
      dec_used = 1'b1;
    end else if (in_instr[31:26] == 6'b000101) begin
      dec_ctrl = 3'b000;
      dec_used = 1'b1;
    end
  end

  always_comb begin
    in_entry.imm26 = in_instr[25:0];
    in_entry.ctrl  = dec_ctrl;
    in_entry.used  = dec_used;
    in_entry.pc    = in_pc;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign acc       = in_valid && in_ready_q;
  assign drn       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            m_d     = in_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (acc && drn) begin
            m_d = in_entry;
          end else if (drn) begin
            state_d = StEmpty;
          end else if (acc) begin
            s_d     = in_entry;
            state_d = StFull;
          end
        end
        StFull: begin
          // in_ready is low here, so only a drain can happen.
          if (drn) begin
            m_d     = s_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
      m_q        <= ResetEntry;
      s_q        <= ResetEntry;
    end else begin
      state_q    <= state_d;
      // Registered from next state so in_ready never sees out_ready combinationally.
      in_ready_q <= (state_d != StFull);
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

  assign out_imm26    = m_q.imm26;
  assign out_ext_ctrl = m_q.ctrl;
  assign out_imm_used = m_q.used;
  assign out_pc       = m_q.pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  logic        CLK;
  logic        resetl;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_imm26;
  logic [2:0]  out_ext_ctrl;
  logic        out_imm_used;
  logic [63:0] out_pc;

  int tests = 0;
  int fails = 0;

  imm_decode_stage #(.PC_W(64), .NOIMM_CTRL(3'b000)) dut (
    .CLK(CLK), .resetl(resetl), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm26(out_imm26),
    .out_ext_ctrl(out_ext_ctrl), .out_imm_used(out_imm_used), .out_pc(out_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference decode: {imm_used, ctrl} from the opcode table.
  function automatic logic [3:0] ref_dec(input logic [31:0] i);
    int unsigned w;
    w = i;
    if ((w >> 21) == 32'h7C2 || (w >> 21) == 32'h7C0) return 4'b1010;
    if ((w >> 22) == 32'h244 || (w >> 22) == 32'h344 ||
        (w >> 22) == 32'h248 || (w >> 22) == 32'h2C8) return 4'b1011;
    if ((w >> 23) == 32'h1A5) return {2'b11, 2'((w >> 21) & 3)};
    if ((w >> 24) == 32'hB4 || (w >> 24) == 32'hB5) return 4'b1001;
    if ((w >> 26) == 32'h05) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [9:0]  ari [4];
    ari = '{10'h244, 10'h344, 10'h248, 10'h2C8};
    r = $urandom;
    case ($urandom_range(0, 6))
      0: r[31:21] = ($urandom_range(0, 1) != 0) ? 11'h7C2 : 11'h7C0;
      1: r[31:22] = ari[$urandom_range(0, 3)];
      2: r[31:23] = 9'h1A5;
      3: r[31:24] = ($urandom_range(0, 1) != 0) ? 8'hB4 : 8'hB5;
      4: r[31:26] = 6'h05;
      default: ;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    resetl = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'hF84083E1; in_pc = 64'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({out_valid, in_ready} !== 2'b00) begin
        fails++;
        $display("FAIL reset_hold cyc%0d valid/ready got %b want 00", i, {out_valid, in_ready});
      end
    end
    tests++;
    if ({out_pc, out_imm26, out_ext_ctrl, out_imm_used} !== '0) begin
      fails++;
      $display("FAIL reset_data got pc=%h imm=%h ctrl=%b used=%b want all 0",
               out_pc, out_imm26, out_ext_ctrl, out_imm_used);
    end
    #2 resetl = 1'b1;
    step();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL reset_release valid/ready got %b want 01", {out_valid, in_ready});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] v [6];
    logic [3:0]  e [6];
    v = '{32'hF84083E1, 32'h91000421, 32'hD2E24680, 32'hB4000060, 32'h14000003, 32'h8B020020};
    e = '{4'b1010, 4'b1011, 4'b1111, 4'b1001, 4'b1000, 4'b0000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = v[i]; in_pc = 64'h40;
      step();
      tests++;
      if ({out_valid, out_imm_used, out_ext_ctrl} !== {1'b1, e[i]}) begin
        fails++;
        $display("FAIL decode_%h valid/used/ctrl got %b want %b", v[i],
                 {out_valid, out_imm_used, out_ext_ctrl}, {1'b1, e[i]});
      end
      tests++;
      if ({out_pc, out_imm26} !== {64'h40, v[i][25:0]}) begin
        fails++;
        $display("FAIL decode_data_%h got pc=%h imm=%h want pc=40 imm=%h", v[i],
                 out_pc, out_imm26, v[i][25:0]);
      end
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL decode_drain out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [3];
    logic [63:0] pcs [3];
    for (int i = 0; i < 3; i++) begin
      ins[i] = gen_instr();
      pcs[i] = 64'h100 * (i + 1);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = ins[0]; in_pc = pcs[0];
    step();
    tests++;
    if ({out_valid, in_ready, out_pc} !== {2'b11, pcs[0]}) begin
      fails++;
      $display("FAIL bp_first got v=%b r=%b pc=%h want v=1 r=1 pc=%h",
               out_valid, in_ready, out_pc, pcs[0]);
    end
    in_instr = ins[1]; in_pc = pcs[1];
    step();
    in_instr = ins[2]; in_pc = pcs[2];
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({out_valid, in_ready, out_pc, out_imm26} !== {2'b10, pcs[0], ins[0][25:0]}) begin
        fails++;
        $display("FAIL bp_hold cyc%0d got v=%b r=%b pc=%h imm=%h want v=1 r=0 pc=%h imm=%h", i,
                 out_valid, in_ready, out_pc, out_imm26, pcs[0], ins[0][25:0]);
      end
      step();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      step();
      tests++;
      if ({out_valid, out_pc, out_imm_used, out_ext_ctrl} !== {1'b1, pcs[i], ref_dec(ins[i])}) begin
        fails++;
        $display("FAIL bp_order_%0d got v=%b pc=%h uc=%b want v=1 pc=%h uc=%b", i,
                 out_valid, out_pc, {out_imm_used, out_ext_ctrl}, pcs[i], ref_dec(ins[i]));
      end
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] ins;
    logic [63:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ins = gen_instr();
      pc = {$urandom, $urandom};
      in_valid = 1'b1; in_instr = ins; in_pc = pc;
      step();
      tests++;
      if ({out_valid, in_ready} !== 2'b11) begin
        fails++;
        $display("FAIL stream_hs_%0d valid/ready got %b want 11", i, {out_valid, in_ready});
      end
      tests++;
      if (out_pc !== pc) begin
        fails++;
        $display("FAIL stream_pc_%0d got %h want %h", i, out_pc, pc);
      end
      tests++;
      if ({out_imm_used, out_ext_ctrl, out_imm26} !== {ref_dec(ins), ins[25:0]}) begin
        fails++;
        $display("FAIL stream_dec_%0d instr=%h got uc=%b imm=%h want uc=%b imm=%h", i, ins,
                 {out_imm_used, out_ext_ctrl}, out_imm26, ref_dec(ins), ins[25:0]);
      end
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_drain out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = gen_instr(); in_pc = 64'hD00;
    step();
    in_instr = gen_instr(); in_pc = 64'hE00;
    step();
    tests++;
    if ({out_valid, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL flush_full valid/ready got %b want 10", {out_valid, in_ready});
    end
    flush = 1'b1; in_instr = gen_instr(); in_pc = 64'hF00;
    step();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL flush_after valid/ready got %b want 01", {out_valid, in_ready});
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_quiet cyc%0d out_valid got %b pc=%h want 0", i, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = gen_instr(); in_pc = 64'h1000;
    step();
    in_instr = gen_instr(); in_pc = 64'h2000;
    step();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL areset_full valid/ready got %b want 10", {out_valid, in_ready});
    end
    #3 resetl = 1'b0;
    #1;
    tests++;
    if ({out_valid, in_ready, out_pc} !== {2'b00, 64'h0}) begin
      fails++;
      $display("FAIL areset_immediate got v=%b r=%b pc=%h want v=0 r=0 pc=0",
               out_valid, in_ready, out_pc);
    end
    #2 resetl = 1'b1;
    out_ready = 1'b1;
    step();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL areset_release valid/ready got %b want 01", {out_valid, in_ready});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL areset_replay cyc%0d out_valid got %b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_streaming();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
